// File: rtl/manchester_decoder.sv
// Manchester (IEEE 802.3 polarity) byte receiver: start bit '1' plus 8 data bits MSB first on an
// idle-low line. Bit timing re-locks on every accepted mid-bit transition.
module manchester_decoder #(
   parameter int unsigned HALF_BIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       line_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned CNT_W = $clog2(5 * HALF_BIT / 2 + 1);

   // cnt = (clk cycles since the line_in mid-bit transition) - 1 once the FSM has seen the edge.
   // Sampling one cycle past the nominal bit boundary keeps the sample inside the first half of
   // the next bit for mid-bit edges anywhere from HALF_BIT/2 early to HALF_BIT/2 late.
   localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(HALF_BIT);
   localparam logic [CNT_W-1:0] WIN_LO    = CNT_W'(3 * HALF_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(5 * HALF_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] GAP_LEN   = CNT_W'(2 * HALF_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {
      StGap,
      StIdle,
      StSample,
      StEdge
   } state_t;

   state_t           r_state;
   logic             r_sync;
   logic             r_line_s;
   logic             r_line_d;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic             r_bit;
   logic [7:0]       r_shift;
   logic [7:0]       r_data;
   logic             r_valid;
   logic             r_err;
   logic             r_busy;

   logic             w_edge;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_edge    = r_line_s ^ r_line_d;
   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync   <= 1'b0;
         r_line_s <= 1'b0;
         r_line_d <= 1'b0;
      end else begin
         r_sync   <= line_in;
         r_line_s <= r_sync;
         r_line_d <= r_line_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StGap;
         r_cnt   <= '0;
         r_idx   <= 3'd0;
         r_bit   <= 1'b0;
         r_shift <= 8'h00;
         r_data  <= 8'h00;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_cnt   <= w_cnt_inc;
         if (!enable) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               StGap: begin
                  if (r_line_s) begin
                     r_cnt <= '0;
                  end else if (r_cnt == GAP_LEN) begin
                     r_state <= StIdle;
                     r_cnt   <= '0;
                  end
               end
               StIdle: begin
                  if (w_edge && r_line_s) begin
                     r_state <= StSample;
                     r_cnt   <= '0;
                     r_idx   <= 3'd0;
                     r_busy  <= 1'b1;
                  end
               end
               StSample: begin
                  if (r_cnt == SAMPLE_AT) begin
                     r_bit   <= ~r_line_s;
                     r_shift <= {r_shift[6:0], ~r_line_s};
                     r_state <= StEdge;
                  end
               end
               StEdge: begin
                  if (w_edge && (r_cnt >= WIN_LO)) begin
                     r_cnt <= '0;
                     if (r_line_s != r_bit) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StGap;
                     end else if (r_idx == 3'd7) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StGap;
                     end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_state <= StSample;
                     end
                  end else if (r_cnt >= TIMEOUT) begin
                     r_cnt   <= '0;
                     r_err   <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= StGap;
                  end
               end
               default: begin
                  r_state <= StGap;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign data_out   = r_data;
   assign data_valid = r_valid;
   assign frame_err  = r_err;
   assign busy       = r_busy;

endmodule

// File: tb/tb_manchester_decoder.sv
// Directed bench for manchester_decoder: table of frames with per-bit jitter, plus hand-timed
// sequences for latency, stuck line, enable abort and asynchronous reset.
module tb_manchester_decoder;

   localparam int H = 4;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       line_in;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   int n_checks;
   int n_pass;
   int n_valid;
   int n_err;
   int n_both;
   int v0;
   int e0;

   typedef struct packed {
      logic [7:0]        data;
      logic signed [3:0] je;
      logic signed [3:0] jo;
      logic              lat;
      logic [7:0]        exp_data;
      logic              exp_valid;
   } vec_t;

   vec_t vecs [8];

   manchester_decoder #(
      .HALF_BIT(H)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .line_in   (line_in),
      .data_out  (data_out),
      .data_valid(data_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (data_valid) n_valid++;
      if (frame_err) n_err++;
      if (data_valid && frame_err) n_both++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic hold(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_start();
      line_in = 1'b0;
      hold(H);
      line_in = 1'b1;
      hold(H);
   endtask

   // Jitter stretches or shrinks the first half, moving the mid-bit edge relative to the last one.
   task automatic drive_bit(input logic b, input int j);
      line_in = ~b;
      hold(H + j);
      line_in = b;
      hold(H);
   endtask

   task automatic send_frame(input logic [7:0] d, input int je, input int jo, input logic lat);
      drive_start();
      for (int i = 0; i < 7; i++) drive_bit(d[7-i], (i % 2 == 0) ? je : jo);
      line_in = ~d[0];
      hold(H + jo);
      line_in = d[0];
      for (int c = 1; c <= H; c++) begin
         hold(1);
         if (lat) begin
            if (c == 2) begin
               check("latency_dv_early", data_valid, 1'b0);
               check("latency_busy_hi", busy, 1'b1);
            end
            if (c == 3) begin
               check("latency_dv_pulse", data_valid, 1'b1);
               check("latency_busy_lo", busy, 1'b0);
               check("latency_data", data_out, d);
            end
            if (c == 4) check("latency_dv_one_cycle", data_valid, 1'b0);
         end
      end
      line_in = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      n_valid  = 0;
      n_err    = 0;
      n_both   = 0;

      vecs[0] = '{8'hA5, 4'sd0, 4'sd0, 1'b1, 8'hA5, 1'b1};
      vecs[1] = '{8'h00, 4'sd0, 4'sd0, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 4'sd0, 4'sd0, 1'b0, 8'hFF, 1'b1};
      vecs[3] = '{8'h3C, 4'sd2, -4'sd2, 1'b0, 8'h3C, 1'b1};
      vecs[4] = '{8'h66, -4'sd2, 4'sd2, 1'b0, 8'h66, 1'b1};
      vecs[5] = '{8'hF0, 4'sd3, 4'sd0, 1'b0, 8'h66, 1'b0};
      vecs[6] = '{8'hC0, 4'sd0, -4'sd3, 1'b0, 8'h66, 1'b0};
      vecs[7] = '{8'h81, 4'sd1, -4'sd1, 1'b0, 8'h81, 1'b1};

      rst_n   = 1'b0;
      enable  = 1'b1;
      line_in = 1'b0;
      hold(3);
      check("reset_data_out", data_out, 8'h00);
      check("reset_valid", data_valid, 1'b0);
      check("reset_err", frame_err, 1'b0);
      check("reset_busy", busy, 1'b0);
      rst_n = 1'b1;
      hold(16);

      for (int k = 0; k < 8; k++) begin
         v0 = n_valid;
         e0 = n_err;
         send_frame(vecs[k].data, int'(vecs[k].je), int'(vecs[k].jo), vecs[k].lat);
         hold(8);
         check($sformatf("vec%0d_valid_count", k), n_valid - v0, {31'd0, vecs[k].exp_valid});
         check($sformatf("vec%0d_err_count", k), n_err - e0, {31'd0, ~vecs[k].exp_valid});
         check($sformatf("vec%0d_data", k), data_out, vecs[k].exp_data);
         check($sformatf("vec%0d_idle_busy", k), busy, 1'b0);
      end

      // Line stuck after the 4th data bit's first half: timeout 9 cycles after that half starts.
      v0 = n_valid;
      e0 = n_err;
      drive_start();
      drive_bit(1'b1, 0);
      drive_bit(1'b0, 0);
      drive_bit(1'b1, 0);
      line_in = 1'b1;
      hold(8);
      check("stuck_err_not_yet", frame_err, 1'b0);
      check("stuck_busy_hi", busy, 1'b1);
      hold(1);
      check("stuck_err_pulse", frame_err, 1'b1);
      check("stuck_busy_lo", busy, 1'b0);
      hold(1);
      check("stuck_err_one_cycle", frame_err, 1'b0);
      line_in = 1'b0;
      hold(16);
      check("stuck_valid_count", n_valid - v0, 0);
      check("stuck_err_count", n_err - e0, 1);
      check("stuck_data_kept", data_out, 8'h81);

      // Enable dropped during bit 5 of 0x5A, then 0xC3.
      v0 = n_valid;
      e0 = n_err;
      drive_start();
      for (int i = 0; i < 5; i++) drive_bit(8'h5A >> (7 - i), 0);
      line_in = 1'b1;
      hold(2);
      enable  = 1'b0;
      line_in = 1'b0;
      hold(1);
      check("abort_busy_lo", busy, 1'b0);
      hold(4);
      enable = 1'b1;
      hold(12);
      check("abort_no_valid", n_valid - v0, 0);
      check("abort_no_err", n_err - e0, 0);
      check("abort_data_kept", data_out, 8'h81);
      send_frame(8'hC3, 0, 0, 1'b0);
      hold(8);
      check("after_abort_valid", n_valid - v0, 1);
      check("after_abort_err", n_err - e0, 0);
      check("after_abort_data", data_out, 8'hC3);

      // Asynchronous reset mid-frame, then 0x81 once the idle gap is satisfied.
      drive_start();
      drive_bit(1'b1, 0);
      drive_bit(1'b0, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_data", data_out, 8'h00);
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_valid", data_valid, 1'b0);
      check("async_rst_err", frame_err, 1'b0);
      line_in = 1'b0;
      hold(2);
      rst_n = 1'b1;
      hold(12);
      v0 = n_valid;
      e0 = n_err;
      send_frame(8'h81, 0, 0, 1'b0);
      hold(8);
      check("post_rst_valid", n_valid - v0, 1);
      check("post_rst_err", n_err - e0, 0);
      check("post_rst_data", data_out, 8'h81);

      check("valid_err_exclusive", n_both, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
